// File: rtl/rv32v_instr_queue.sv
// Vector instruction queue between fetch and decode: circular buffer with flush/redirect FSM.
// Latency: enqueue visible at head one cycle after the accepting edge; head fields are combinational.
// Backpressure: enq_ready drops when full or flushing; busy_dec holds the head entry stable.
module rv32v_instr_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       enq_valid,
    input  logic [31:0]                enq_instr,
    input  logic [TAGW-1:0]            enq_line,
    input  logic                       enq_fault,
    input  logic                       enq_mal,
    output logic                       enq_ready,
    input  logic                       busy_dec,
    input  logic                       csr_update,
    input  logic [TAGW-1:0]            restart_line,
    output logic [31:0]                instr,
    output logic [TAGW-1:0]            tb_line_num,
    output logic                       fault_insn,
    output logic                       mal_insn,
    output logic                       deq_valid,
    output logic                       redirect,
    output logic [TAGW-1:0]            redirect_line,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [TAGW-1:0]   redir_line_q, redir_line_d;
    logic [TAGW-1:0]   last_line_q, last_line_d;
    logic              do_enq, do_deq;

    logic [31:0]       instr_mem [DEPTH];
    logic [TAGW-1:0]   line_mem  [DEPTH];
    logic              fault_mem [DEPTH];
    logic              mal_mem   [DEPTH];

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        redir_line_d  = redir_line_q;
        last_line_d   = last_line_q;
        enq_ready     = (state_q == RUN) && (count_q < DEPTH_C);
        deq_valid     = (state_q == RUN) && (count_q != '0);
        redirect      = (state_q == FLUSH);
        // Flush wins: any transfer in the csr_update cycle is dropped.
        do_enq        = enq_valid && enq_ready && !csr_update;
        do_deq        = deq_valid && !busy_dec && !csr_update;

        instr         = 32'h0;
        fault_insn    = 1'b0;
        mal_insn      = 1'b0;
        tb_line_num   = last_line_q;
        if (deq_valid) begin
            instr       = instr_mem[head_q];
            tb_line_num = line_mem[head_q];
            fault_insn  = fault_mem[head_q];
            mal_insn    = mal_mem[head_q];
        end

        if (do_enq) tail_d = tail_q + PW'(1);
        if (do_deq) begin
            head_d      = head_q + PW'(1);
            last_line_d = line_mem[head_q];
        end
        if (do_enq && !do_deq) count_d = count_q + CW'(1);
        if (!do_enq && do_deq) count_d = count_q - CW'(1);

        case (state_q)
            RUN:     state_d = csr_update ? FLUSH : RUN;
            FLUSH:   state_d = csr_update ? FLUSH : RUN;
            default: state_d = RUN;
        endcase

        if (csr_update) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            redir_line_d = restart_line;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= RUN;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            redir_line_q <= '0;
            last_line_q  <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            redir_line_q <= redir_line_d;
            last_line_q  <= last_line_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge CLK) begin
        if (!RST && do_enq) begin
            instr_mem[tail_q] <= enq_instr;
            line_mem[tail_q]  <= enq_line;
            fault_mem[tail_q] <= enq_fault;
            mal_mem[tail_q]   <= enq_mal;
        end
    end

    assign redirect_line = redir_line_q;
    assign count         = count_q;

endmodule

// File: tb/tb_rv32v_instr_queue.sv
// Directed bench for rv32v_instr_queue with DEPTH=4, TAGW=16.
module tb_rv32v_instr_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enq_valid;
    logic [31:0] enq_instr;
    logic [15:0] enq_line;
    logic        enq_fault, enq_mal, enq_ready;
    logic        busy_dec, csr_update;
    logic [15:0] restart_line;
    logic [31:0] instr;
    logic [15:0] tb_line_num;
    logic        fault_insn, mal_insn, deq_valid, redirect;
    logic [15:0] redirect_line;
    logic [2:0]  count;

    int total = 0;
    int passed = 0;
    int failed = 0;

    rv32v_instr_queue #(.DEPTH(4), .TAGW(16)) dut (
        .CLK(CLK), .RST(RST),
        .enq_valid(enq_valid), .enq_instr(enq_instr), .enq_line(enq_line),
        .enq_fault(enq_fault), .enq_mal(enq_mal), .enq_ready(enq_ready),
        .busy_dec(busy_dec), .csr_update(csr_update), .restart_line(restart_line),
        .instr(instr), .tb_line_num(tb_line_num), .fault_insn(fault_insn),
        .mal_insn(mal_insn), .deq_valid(deq_valid), .redirect(redirect),
        .redirect_line(redirect_line), .count(count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word(input int n);
        return 32'hA500_0000 | 32'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_enq(input logic v, input int n, input logic f, input logic m);
        enq_valid = v;
        enq_instr = word(n);
        enq_line  = 16'(n);
        enq_fault = f;
        enq_mal   = m;
    endtask

    initial begin
        RST = 1'b1; busy_dec = 1'b1; csr_update = 1'b0; restart_line = '0;
        drive_enq(1'b1, 50, 1'b0, 1'b0);
        csr_update = 1'b1;
        tick(); tick();
        RST = 1'b0; csr_update = 1'b0; drive_enq(1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("rst_enq_ready", 32'(enq_ready), 32'd1);
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_redirect_line", 32'(redirect_line), 32'd0);
        chk("rst_tb_line", 32'(tb_line_num), 32'd0);

        // Fill with decode stalled: fifth attempt refused
        busy_dec = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_enq(1'b1, i, (i == 1), (i == 2));
            settle();
            chk($sformatf("fill_ready_%0d", i), 32'(enq_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        drive_enq(1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_deq_valid", 32'(deq_valid), 32'd1);
        chk("fill_instr", instr, word(0));

        // Drain in order
        busy_dec = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("drain_instr_%0d", i), instr, word(i));
            chk($sformatf("drain_line_%0d", i), 32'(tb_line_num), 32'(i));
            chk($sformatf("drain_fault_%0d", i), 32'(fault_insn), (i == 1) ? 32'd1 : 32'd0);
            chk($sformatf("drain_mal_%0d", i), 32'(mal_insn), (i == 2) ? 32'd1 : 32'd0);
            chk($sformatf("drain_count_%0d", i), 32'(count), 32'(4 - i));
            tick();
        end
        settle();
        chk("drained_deq_valid", 32'(deq_valid), 32'd0);
        chk("drained_instr", instr, 32'h0);
        chk("drained_line_hold", 32'(tb_line_num), 32'd3);

        // Wrap-around with count held at 2
        busy_dec = 1'b1;
        drive_enq(1'b1, 100, 1'b0, 1'b0); tick();
        drive_enq(1'b1, 101, 1'b0, 1'b0); tick();
        busy_dec = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive_enq(1'b1, 102 + k, 1'b0, 1'b0);
            settle();
            chk($sformatf("wrap_instr_%0d", k), instr, word(100 + k));
            chk($sformatf("wrap_count_%0d", k), 32'(count), 32'd2);
            tick();
        end
        busy_dec = 1'b1;
        drive_enq(1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("wrap_final_count", 32'(count), 32'd2);
        chk("wrap_final_instr", instr, word(110));

        // Flush with count=3
        drive_enq(1'b1, 112, 1'b0, 1'b0); tick();
        drive_enq(1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("preflush_count", 32'(count), 32'd3);
        csr_update = 1'b1; restart_line = 16'd7;
        tick();
        csr_update = 1'b0;
        settle();
        chk("flush_redirect", 32'(redirect), 32'd1);
        chk("flush_redirect_line", 32'(redirect_line), 32'd7);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_enq_ready", 32'(enq_ready), 32'd0);
        chk("flush_deq_valid", 32'(deq_valid), 32'd0);
        chk("flush_line_hold", 32'(tb_line_num), 32'd109);
        tick();
        chk("resume_redirect", 32'(redirect), 32'd0);
        chk("resume_enq_ready", 32'(enq_ready), 32'd1);

        // csr_update during FLUSH re-latches and extends
        csr_update = 1'b1; restart_line = 16'd8; tick();
        restart_line = 16'd9; tick();
        csr_update = 1'b0;
        settle();
        chk("reflush_redirect", 32'(redirect), 32'd1);
        chk("reflush_line", 32'(redirect_line), 32'd9);
        tick();
        chk("reflush_exit", 32'(redirect), 32'd0);

        // Enqueue, dequeue and csr_update together
        busy_dec = 1'b1;
        drive_enq(1'b1, 20, 1'b0, 1'b0); tick();
        busy_dec = 1'b0;
        drive_enq(1'b1, 21, 1'b0, 1'b0);
        csr_update = 1'b1; restart_line = 16'd5;
        settle();
        chk("simul_pre_count", 32'(count), 32'd1);
        tick();
        csr_update = 1'b0; drive_enq(1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("simul_count", 32'(count), 32'd0);
        chk("simul_redirect_line", 32'(redirect_line), 32'd5);
        tick();
        chk("simul_after_count", 32'(count), 32'd0);
        chk("simul_after_deq_valid", 32'(deq_valid), 32'd0);

        // Reset while in FLUSH after a partial fill
        busy_dec = 1'b1;
        drive_enq(1'b1, 30, 1'b0, 1'b0); tick();
        drive_enq(1'b1, 31, 1'b0, 1'b0); tick();
        drive_enq(1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("prerst_count", 32'(count), 32'd2);
        csr_update = 1'b1; restart_line = 16'd3; tick();
        settle();
        chk("prerst_redirect", 32'(redirect), 32'd1);
        RST = 1'b1; drive_enq(1'b1, 40, 1'b0, 1'b0);
        tick();
        RST = 1'b0; csr_update = 1'b0; drive_enq(1'b0, 0, 1'b0, 1'b0);
        settle();
        chk("midrst_redirect", 32'(redirect), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_enq_ready", 32'(enq_ready), 32'd1);
        chk("midrst_redirect_line", 32'(redirect_line), 32'd0);
        chk("midrst_tb_line", 32'(tb_line_num), 32'd0);
        chk("midrst_instr", instr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
